// File: rtl/aes_pkg.sv
// Shared AES definitions: byte count, state byte indexing, FSM encoding and the
// forward S-box contents.
package aes_pkg;

  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  // Byte i of a 128-bit state sits at bits [127-8i -: 8]; 127-8i == {~i, 3'b111}.
  function automatic logic [6:0] byte_msb(input logic [3:0] idx);
    return {~idx, 3'b111};
  endfunction

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/sbox.sv
// Registered forward S-box ROM, one lookup per cycle, 1-cycle latency.
// No reset and no backpressure: the output register follows the address every cycle.
module sbox
  import aes_pkg::*;
#(
  parameter string SBOX_FILE = "../rtl/sbox.dat"
) (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] dat
);

  // The table is compiled in from aes_pkg; SBOX_FILE names the equivalent hex image.
  if (SBOX_FILE == "") begin : g_no_image
  end

  always_ff @(posedge clk) begin
    dat <= SBOX_TBL[addr];
  end

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: 16 bytes through one registered S-box, 17 cycles accept-to-out_valid.
// Accepts only in IDLE; holds the result in DONE until out_ready.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter string SBOX_FILE = "../rtl/sbox.dat"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  fsm_t         state_q;
  fsm_t         state_d;
  logic [127:0] state_reg;
  logic [4:0]   issue_idx;
  logic [3:0]   wr_idx;
  logic         wr_vld;
  logic         issue_en;
  logic         accept;
  logic         last_wr;
  logic [7:0]   rom_addr;
  logic [7:0]   rom_dat;

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign issue_en = (state_q == ST_RUN) && (issue_idx < 5'(AES_BYTES));
  assign last_wr  = wr_vld && (wr_idx == 4'(AES_BYTES - 1));
  assign rom_addr = state_reg[byte_msb(issue_idx[3:0]) -: 8];

  sbox #(
    .SBOX_FILE (SBOX_FILE)
  ) u_sbox (
    .clk  (clk),
    .addr (rom_addr),
    .dat  (rom_dat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_wr) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      state_reg <= '0;
      issue_idx <= '0;
      wr_idx    <= '0;
      wr_vld    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Writeback trails issue by the ROM latency, so it carries its own index copy.
      wr_vld  <= issue_en;
      wr_idx  <= issue_idx[3:0];
      if (accept) begin
        state_reg <= in_state;
        issue_idx <= '0;
      end else begin
        if (issue_en) issue_idx <= issue_idx + 5'd1;
        if (wr_vld) state_reg[byte_msb(wr_idx) -: 8] <= rom_dat;
      end
    end
  end

endmodule
